// File: rtl/phased_delay_array_if.sv
// Steering-configuration handshake between the control logic (master)
// and the phased delay array (slave).
interface phased_delay_array_if #(
  parameter int STEP_W = 10
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [STEP_W-1:0] cfg_step;
  logic              cfg_dir;
  logic              cfg_done;
  logic              cfg_err;

  modport master (
    output cfg_valid, cfg_step, cfg_dir,
    input  cfg_ready, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_step, cfg_dir,
    output cfg_ready, cfg_done, cfg_err
  );
endinterface

// File: rtl/phased_delay_array.sv
// Multi-channel phased delay line: circular sample buffer with one programmable
// read tap per channel; new tap delays are computed serially and swapped in on a strobe.
module phased_delay_array #(
  parameter int N_CH   = 20,
  parameter int DEPTH  = 1024,
  parameter int STEP_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_en,
  input  logic                  din,
  phased_delay_array_if.slave   cfg,
  output logic [N_CH-1:0]       dout
);
  localparam int AW = $clog2(DEPTH);
  localparam int KW = $clog2(N_CH);

  typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

  state_t            state_reg, state_next;
  logic              buf_mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [STEP_W-1:0] step_reg;
  logic              dir_reg;
  logic [AW-1:0]     acc_reg;
  logic [KW-1:0]     k_reg;
  logic              cfg_done_reg;
  logic              cfg_err_reg;

  logic              handshake;
  logic              step_legal;
  logic              calc_last;
  logic              calc_active;
  logic              commit_fire;
  logic              cfg_ready_int;
  logic [31:0]       span;
  logic [AW-1:0]     step_aw;
  logic [KW-1:0]     wr_idx;

  assign handshake  = cfg.cfg_valid & cfg_ready_int;
  // Widest delay the requested step would produce; must fit inside the buffer.
  assign span       = 32'(N_CH - 1) * 32'(cfg.cfg_step);
  assign step_legal = (span <= 32'(DEPTH - 1));
  // A legal step never exceeds DEPTH-1, so narrowing to the address width is lossless.
  assign step_aw    = AW'(step_reg);
  assign calc_last  = (k_reg == KW'(N_CH - 1));
  assign wr_idx     = dir_reg ? k_reg : (KW'(N_CH - 1) - k_reg);

  assign cfg.cfg_ready = cfg_ready_int;
  assign cfg.cfg_done  = cfg_done_reg;
  assign cfg.cfg_err   = cfg_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (handshake && step_legal) state_next = CALC;
      CALC:    if (calc_last) state_next = COMMIT;
      COMMIT:  if (sample_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready_int = 1'b0;
    calc_active   = 1'b0;
    commit_fire   = 1'b0;
    case (state_reg)
      IDLE:    cfg_ready_int = 1'b1;
      CALC:    calc_active   = 1'b1;
      COMMIT:  commit_fire   = sample_en;
      default: ;
    endcase
  end

  // Config latch and the multiplier-free accumulator that walks the channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_reg     <= '0;
      dir_reg      <= 1'b0;
      acc_reg      <= '0;
      k_reg        <= '0;
      cfg_done_reg <= 1'b0;
      cfg_err_reg  <= 1'b0;
    end else begin
      cfg_done_reg <= commit_fire;
      cfg_err_reg  <= handshake & ~step_legal;
      if (handshake) begin
        step_reg <= cfg.cfg_step;
        dir_reg  <= cfg.cfg_dir;
        acc_reg  <= '0;
        k_reg    <= '0;
      end else if (calc_active) begin
        acc_reg <= acc_reg + step_aw;
        k_reg   <= k_reg + KW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_mem[i] <= 1'b0;
      end
    end else if (sample_en) begin
      buf_mem[wr_ptr_reg] <= din;
      wr_ptr_reg          <= wr_ptr_reg + AW'(1);
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [AW-1:0] shadow_reg;
    logic [AW-1:0] delay_reg;
    logic [AW-1:0] rd_addr;
    logic          dout_reg;

    assign rd_addr  = wr_ptr_reg - delay_reg;
    assign dout[gi] = dout_reg;

    // Reads on the commit edge still see the old delay; the swap lands after it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_reg <= '0;
        delay_reg  <= '0;
        dout_reg   <= 1'b0;
      end else begin
        if (calc_active && (wr_idx == KW'(gi))) begin
          shadow_reg <= acc_reg;
        end
        if (sample_en) begin
          dout_reg <= (delay_reg == '0) ? din : buf_mem[rd_addr];
        end
        if (commit_fire) begin
          delay_reg <= shadow_reg;
        end
      end
    end
  end
endmodule

// File: tb/tb_phased_delay_array.sv
// Scoreboard bench: the driver pushes the per-cycle expected outputs from a sample-history
// model, and an independent monitor pops and compares them just after every clock edge.
module tb_phased_delay_array;
  localparam int N_CH   = 4;
  localparam int DEPTH  = 16;
  localparam int STEP_W = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sample_en = 1'b0;
  logic            din = 1'b0;
  logic [N_CH-1:0] dout;

  phased_delay_array_if #(.STEP_W(STEP_W)) cfg_if ();

  phased_delay_array #(.N_CH(N_CH), .DEPTH(DEPTH), .STEP_W(STEP_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (sample_en),
    .din       (din),
    .cfg       (cfg_if),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_CH-1:0] dout;
    logic            done;
    logic            err;
    logic            ready;
    string           tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: plain history of written samples and integer delay tables.
  int              cur_delay  [N_CH];
  int              pend_delay [N_CH];
  bit              busy;
  int              since;
  bit              hist[$];
  logic [N_CH-1:0] m_dout;

  bit              req_valid = 1'b0;
  int              req_step  = 0;
  bit              req_dir   = 1'b0;
  string           phase     = "reset";

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      cur_delay[i]  = 0;
      pend_delay[i] = 0;
    end
    busy   = 1'b0;
    since  = 0;
    m_dout = '0;
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back(1'b0);
  endtask

  task automatic tick(input bit rst_in, input bit en, input bit d);
    exp_t e;
    bit   accepted;
    accepted         = 1'b0;
    rst_n            = rst_in;
    sample_en        = en;
    din              = d;
    cfg_if.cfg_valid = req_valid;
    cfg_if.cfg_step  = STEP_W'(req_step);
    cfg_if.cfg_dir   = req_dir;
    e.done = 1'b0;
    e.err  = 1'b0;
    e.tag  = phase;
    if (!rst_in) begin
      model_reset();
    end else begin
      if (en) begin
        for (int i = 0; i < N_CH; i++)
          m_dout[i] = (cur_delay[i] == 0) ? d : hist[hist.size() - cur_delay[i]];
      end
      if (busy) begin
        since++;
        if (since >= N_CH + 1 && en) begin
          for (int i = 0; i < N_CH; i++) cur_delay[i] = pend_delay[i];
          busy   = 1'b0;
          e.done = 1'b1;
        end
      end else if (req_valid) begin
        accepted = 1'b1;
        if ((N_CH - 1) * req_step > DEPTH - 1) begin
          e.err = 1'b1;
        end else begin
          busy  = 1'b1;
          since = 0;
          for (int i = 0; i < N_CH; i++)
            pend_delay[i] = req_dir ? i * req_step : (N_CH - 1 - i) * req_step;
        end
      end
      if (en) begin
        hist.push_back(d);
        void'(hist.pop_front());
      end
    end
    e.dout  = m_dout;
    e.ready = !busy;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    if (accepted) req_valid = 1'b0;
  endtask

  task automatic request(input int step, input bit dir);
    req_valid = 1'b1;
    req_step  = step;
    req_dir   = dir;
  endtask

  task automatic impulse(input int pre, input int post);
    for (int i = 0; i < pre; i++) tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < post; i++) tick(1'b1, 1'b1, 1'b0);
  endtask

  task automatic chk(input string name, input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL [%s] %s: got %0h expected %0h at %0t", tag, name, got, want, $time);
    end
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dout",      e.tag, 32'(dout),             32'(e.dout));
      chk("cfg_done",  e.tag, 32'(cfg_if.cfg_done),  32'(e.done));
      chk("cfg_err",   e.tag, 32'(cfg_if.cfg_err),   32'(e.err));
      chk("cfg_ready", e.tag, 32'(cfg_if.cfg_ready), 32'(e.ready));
    end
  end

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_step  = '0;
    cfg_if.cfg_dir   = 1'b0;
    model_reset();

    phase = "reset";
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);

    phase = "toggle_no_cfg";
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, i[0]);

    phase = "step3_dir1";
    request(3, 1'b1);
    impulse(8, 20);

    phase = "step3_dir0";
    request(3, 1'b0);
    impulse(8, 20);

    phase = "step5_wrap";
    request(5, 1'b0);
    impulse(8, 4);
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b1, 1'($urandom_range(0, 1)));

    phase = "step6_reject";
    request(6, 1'b1);
    impulse(4, 20);

    phase = "sparse_strobe";
    for (int i = 0; i < 80; i++) begin
      if (i == 10) request(2, 1'b1);
      tick(1'b1, (i % 4) == 3, 1'($urandom_range(0, 1)));
    end

    phase = "reset_mid_calc";
    request(3, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'($urandom_range(0, 1)));

    phase = "random";
    for (int i = 0; i < 300; i++) begin
      if (!req_valid && $urandom_range(0, 19) == 0)
        request(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      tick(1'b1, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
    end

    phase = "drain";
    @(posedge clk);
    #3;
    chk("queue_drained", phase, 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
